// File: rtl/tile_sequencer.sv
// Hands a one-cycle control token forward/backward across NUM_TILES solver tiles.
// Optional SEQ_STEP_LIMIT_EN bounds the number of grants per solve to STEP_LIMIT.
module tile_sequencer #(
  parameter int          NUM_TILES  = 16,
  parameter int          IDX_W      = $clog2(NUM_TILES),
  parameter int unsigned STEP_LIMIT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_TILES-1:0] passfwd,
  input  logic [NUM_TILES-1:0] passbak,
  output logic [NUM_TILES-1:0] myturn,
  output logic [IDX_W-1:0]     cur_index,
  output logic                 busy,
  output logic                 done,
  output logic                 fail
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE, S_FAIL} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fwd_hit, bak_hit;

  assign fwd_hit = passfwd[idx_q];
  assign bak_hit = passbak[idx_q];

`ifdef SEQ_STEP_LIMIT_EN
  logic [31:0] step_q, step_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_WAIT;
      S_WAIT: begin
        // Backtrack wins over a simultaneous forward pass on the owning tile.
        if (bak_hit) begin
          if (idx_q == '0) begin
            state_d = S_FAIL;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_GRANT;
          end
        end else if (fwd_hit) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_GRANT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SEQ_STEP_LIMIT_EN
    step_d = step_q;
    if (state_q == S_GRANT) begin
      step_d = step_q + 32'd1;
    end
    if (start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL)) begin
      step_d = '0;
    end
    // Budget exhausted: refuse the next grant and report failure instead.
    if (state_d == S_GRANT && step_d == 32'(STEP_LIMIT)) begin
      state_d = S_FAIL;
    end
`endif

    if (abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
`ifdef SEQ_STEP_LIMIT_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef SEQ_STEP_LIMIT_EN
      step_q  <= step_d;
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_turn
    assign myturn[gi] = (state_q == S_GRANT) && (idx_q == IDX_W'(gi));
  end

  assign cur_index = idx_q;
  assign busy      = (state_q == S_GRANT) || (state_q == S_WAIT);
  assign done      = (state_q == S_DONE);
  assign fail      = (state_q == S_FAIL);

endmodule
